// File: rtl/tcm_loader_pkg.sv
// Shared definitions for the TCM boot loader: FSM states, error codes and header size.
package tcm_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;

  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/tcm_word_packer.sv
// Packs payload bytes little-endian into SRAM words and issues one-cycle byte-enabled writes.
module tcm_word_packer
  import tcm_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            push_i,
  input  logic                            flush_i,
  input  logic [7:0]                      byte_i,
  output logic                            wr_o,
  output logic [DATA_WIDTH/8-1:0]         wr_be_o,
  output logic [$clog2(N_ENTRIES)-1:0]    wr_addr_o,
  output logic [DATA_WIDTH-1:0]           wr_data_o
);

  localparam int unsigned BPW = DATA_WIDTH / 8;
  localparam int unsigned LW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned AW  = $clog2(N_ENTRIES);

  logic [LW-1:0]         lane_q, lane_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, acc_c;
  logic [BPW-1:0]        be_q, be_d, be_c;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [BPW-1:0]        wr_be_q, wr_be_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  full_c;

  // Word contents including the incoming byte; unfilled lanes stay zero.
  always_comb begin
    acc_c  = acc_q | (DATA_WIDTH'(byte_i) << {lane_q, 3'b000});
    be_c   = be_q | (BPW'(1) << lane_q);
    full_c = (lane_q == LW'(BPW - 1));

    lane_d    = lane_q;
    acc_d     = acc_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wr_d      = 1'b0;
    wr_be_d   = wr_be_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (clear_i) begin
      lane_d = '0;
      acc_d  = '0;
      be_d   = '0;
      addr_d = '0;
    end else if (push_i) begin
      if (full_c || flush_i) begin
        wr_d      = 1'b1;
        wr_be_d   = be_c;
        wr_data_d = acc_c;
        wr_addr_d = addr_q;
        addr_d    = addr_q + AW'(1);
        lane_d    = '0;
        acc_d     = '0;
        be_d      = '0;
      end else begin
        lane_d = lane_q + LW'(1);
        acc_d  = acc_c;
        be_d   = be_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q    <= '0;
      acc_q     <= '0;
      be_q      <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wr_be_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wr_be_q   <= wr_be_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_o      = wr_q;
  assign wr_be_o   = wr_be_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/tcm_loader.sv
// Boot loader: parses length header, streams payload into TCM SRAM, verifies trailing checksum.
module tcm_loader
  import tcm_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_data_i,
  output logic                         rx_ready_o,
  output logic                         sram_en_o,
  output logic                         sram_we_o,
  output logic [DATA_WIDTH/8-1:0]      sram_be_o,
  output logic [$clog2(N_ENTRIES)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   err_o
);

  localparam logic [32:0] CAP = 33'(N_ENTRIES * (DATA_WIDTH / 8));

  state_e      state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [1:0]  err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        accept_c, clear_c, push_c, flush_c;
  logic [7:0]  sum_c;
  logic        wr_c;

  assign accept_c = rx_valid_i & ready_q;
  assign sum_c    = sum_q + rx_data_i;

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    err_d      = err_q;
    done_d     = 1'b0;
    clear_c    = 1'b0;
    push_c     = 1'b0;
    flush_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_LEN;
          hdr_cnt_d  = '0;
          len_d      = '0;
          byte_cnt_d = '0;
          sum_d      = '0;
          err_d      = ERR_NONE;
          clear_c    = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept_c) begin
          // Header arrives LSB first, so shift each byte in from the top.
          len_d     = {rx_data_i, len_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            if ({1'b0, len_d} > CAP) begin
              err_d   = ERR_LEN;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (len_d == 32'd0) begin
              state_d = ST_SUM;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (accept_c) begin
          push_c     = 1'b1;
          sum_d      = sum_c;
          byte_cnt_d = byte_cnt_q + 32'd1;
          if (byte_cnt_q == len_q - 32'd1) begin
            flush_c = 1'b1;
            state_d = ST_SUM;
          end
        end
      end
      ST_SUM: begin
        if (accept_c) begin
          if (sum_c != 8'd0) err_d = ERR_SUM;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hdr_cnt_q  <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      sum_q      <= '0;
      err_q      <= ERR_NONE;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  tcm_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_ENTRIES  (N_ENTRIES)
  ) u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear_c),
    .push_i    (push_c),
    .flush_i   (flush_c),
    .byte_i    (rx_data_i),
    .wr_o      (wr_c),
    .wr_be_o   (sram_be_o),
    .wr_addr_o (sram_addr_o),
    .wr_data_o (sram_data_o)
  );

  assign sram_en_o  = wr_c;
  assign sram_we_o  = wr_c;
  assign rx_ready_o = ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_tcm_loader.sv
// Randomized self-checking bench for tcm_loader against a byte-stream reference model.
module tb_tcm_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned NE  = 1024;
  localparam int unsigned BPW = DW / 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned CAP = NE * BPW;

  logic          clk = 1'b0;
  logic          rst_i, start_i, rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          rx_ready_o, sram_en_o, sram_we_o, busy_o, done_o;
  logic [BPW-1:0] sram_be_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_data_o;
  logic [1:0]    err_o;

  tcm_loader #(.DATA_WIDTH(DW), .N_ENTRIES(NE)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .sram_en_o   (sram_en_o),
    .sram_we_o   (sram_we_o),
    .sram_be_o   (sram_be_o),
    .sram_addr_o (sram_addr_o),
    .sram_data_o (sram_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BPW-1:0] be;
    logic [DW-1:0]  data;
  } wr_t;

  int unsigned cyc = 0;
  wr_t         got_q[$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  logic [1:0]  done_err = 2'd0;
  logic        done_busy = 1'b0;
  int unsigned last_acc_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe SRAM writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (sram_en_o) got_q.push_back({sram_we_o, sram_addr_o, sram_be_o, sram_data_o});
    if (done_o) begin
      done_cnt++;
      done_cyc  = cyc;
      done_err  = err_o;
      done_busy = busy_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    int tmo = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        rx_valid_i = 1'b0;
        rx_data_i  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    start_i    = pulse_start;
    while (!rx_ready_o && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("rx_ready_timeout", 64'(rx_ready_o), 64'd1);
    @(negedge clk);
    last_acc_cyc = cyc;
    rx_valid_i   = 1'b0;
    start_i      = 1'b0;
  endtask

  task automatic run_load(input string name, input logic [31:0] n, input logic [7:0] pl[$],
                          input logic [7:0] c, input bit gaps, input int start_at);
    wr_t         exp_q[$];
    wr_t         e;
    logic [1:0]  exp_err;
    logic [7:0]  s;
    logic [31:0] hdr;
    hdr = n;
    s   = c;
    foreach (pl[i]) s = s + pl[i];
    exp_err = (n > CAP) ? 2'd1 : (s != 8'd0) ? 2'd2 : 2'd0;
    if (exp_err != 2'd1) begin
      for (int w = 0; w * BPW < n; w++) begin
        e      = '0;
        e.we   = 1'b1;
        e.addr = AW'(w);
        for (int l = 0; l < BPW; l++) begin
          if (w * BPW + l < n) begin
            e.data[8*l +: 8] = pl[w * BPW + l];
            e.be[l]          = 1'b1;
          end
        end
        exp_q.push_back(e);
      end
    end

    got_q.delete();
    done_cnt = 0;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({name, ":busy_rise"}, 64'(busy_o), 64'd1);
    for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], gaps, 1'b0);
    if (n <= CAP) begin
      for (int i = 0; i < pl.size(); i++) send_byte(pl[i], gaps, i == start_at);
      send_byte(c, gaps, 1'b0);
    end
    repeat (3) @(negedge clk);

    check({name, ":done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, ":done_cyc"}, 64'(done_cyc), 64'(last_acc_cyc));
    check({name, ":done_err"}, 64'(done_err), 64'(exp_err));
    check({name, ":busy_at_done"}, 64'(done_busy), 64'd0);
    check({name, ":err_held"}, 64'(err_o), 64'(exp_err));
    check({name, ":n_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, ":write"}, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  logic [7:0] pl1[$], pl2[$], plz[$], pe[$], pr[$];
  logic [7:0] rs;
  int unsigned rn;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst:rx_ready", 64'(rx_ready_o), 64'd0);
    check("rst:sram_en", 64'(sram_en_o), 64'd0);
    check("rst:sram_we", 64'(sram_we_o), 64'd0);
    check("rst:sram_be", 64'(sram_be_o), 64'd0);
    check("rst:sram_addr", 64'(sram_addr_o), 64'd0);
    check("rst:sram_data", 64'(sram_data_o), 64'd0);
    check("rst:busy", 64'(busy_o), 64'd0);
    check("rst:done", 64'(done_o), 64'd0);
    check("rst:err", 64'(err_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    pl1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pl2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < CAP; i++) plz.push_back(8'h00);

    run_load("c1", 32'd8, pl1, 8'hDC, 1'b0, -1);
    run_load("c2", 32'd5, pl2, 8'h04, 1'b0, -1);
    run_load("c3_badsum", 32'd8, pl1, 8'hDD, 1'b0, -1);
    run_load("c4_toolong", 32'(CAP + 1), pe, 8'h00, 1'b0, -1);
    run_load("c4_full", 32'(CAP), plz, 8'h00, 1'b0, -1);
    run_load("c5_gaps", 32'd5, pl2, 8'h04, 1'b1, -1);

    // Reset in the middle of a payload.
    got_q.delete();
    done_cnt = 0;
    start_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(pl2[i], 1'b0, 1'b0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("c5_rst:busy", 64'(busy_o), 64'd0);
    check("c5_rst:rx_ready", 64'(rx_ready_o), 64'd0);
    check("c5_rst:sram_en", 64'(sram_en_o), 64'd0);
    repeat (5) @(negedge clk);
    check("c5_rst:n_writes", 64'(got_q.size()), 64'd0);
    check("c5_rst:done_cnt", 64'(done_cnt), 64'd0);
    run_load("c5_after_rst", 32'd8, pl1, 8'hDC, 1'b0, -1);

    run_load("c6_empty", 32'd0, pe, 8'h00, 1'b0, -1);
    run_load("c6_midstart", 32'd8, pl1, 8'hDC, 1'b0, 3);

    for (int t = 0; t < 8; t++) begin
      pr.delete();
      rn = $urandom_range(0, 23);
      rs = 8'd0;
      for (int i = 0; i < rn; i++) begin
        pr.push_back(8'($urandom));
        rs = rs + pr[i];
      end
      run_load("rand", 32'(rn), pr, ($urandom_range(0, 1) != 0) ? 8'(-rs) : 8'($urandom),
               1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
